// File: rtl/delay_line_interp.sv
// Circular delay line returning a linear interpolation between the two stored samples that bracket a fractional delay.
// Latency 6 cycles from input strobe to output strobe; no backpressure: a strobe arriving mid-sample is dropped and latches errorLED.
module delay_line_interp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14,
    parameter int BUF_DEPTH  = 4410,
    parameter int AVG_DELAY  = 882,
    parameter int FRAC_BITS  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic signed [DATA_WIDTH-1:0]          pkt_s_i,
    input  logic                                  pktChanged_s_i,
    input  logic signed [ADDR_WIDTH+FRAC_BITS-1:0] extraDelay_s_i,
    input  logic                                  LFOChanged_s_i,
    output logic signed [DATA_WIDTH-1:0]          pktDelayed_s_o,
    output logic                                  pktDelayedChanged_c_o,
    output logic                                  errorLED_s_o
);
    localparam int EW = ADDR_WIDTH + FRAC_BITS;
    localparam int DW = ADDR_WIDTH + FRAC_BITS + 2;
    localparam int CW = ADDR_WIDTH + 1;
    localparam int PW = DATA_WIDTH + FRAC_BITS + 2;
    localparam int IW = (BUF_DEPTH > 2) ? $clog2(BUF_DEPTH) : 1;

    if (BUF_DEPTH < 4) begin : g_badDepth
        $fatal(1, "delay_line_interp: BUF_DEPTH must be at least 4");
    end
    if (longint'(BUF_DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_badAddr
        $fatal(1, "delay_line_interp: BUF_DEPTH exceeds 2**ADDR_WIDTH");
    end
    if (AVG_DELAY > BUF_DEPTH - 2) begin : g_badAvg
        $fatal(1, "delay_line_interp: AVG_DELAY must not exceed BUF_DEPTH-2");
    end
    if (FRAC_BITS < 1) begin : g_badFrac
        $fatal(1, "delay_line_interp: FRAC_BITS must be at least 1");
    end

    localparam logic signed [DW-1:0] D_AVG     = DW'(longint'(AVG_DELAY) << FRAC_BITS);
    localparam logic signed [DW-1:0] D_MAX     = DW'(longint'(BUF_DEPTH - 2) << FRAC_BITS);
    localparam logic [CW-1:0]        DEPTH_C   = CW'(BUF_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BUF_DEPTH - 1);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_IDLE   = 4'd1,
        S_WRITE  = 4'd2,
        S_WAIT   = 4'd3,
        S_READ_A = 4'd4,
        S_READ_B = 4'd5,
        S_INTERP = 4'd6,
        S_OUTPUT = 4'd7,
        S_ERROR  = 4'd8
    } state_t;

    state_t                       state;
    logic [ADDR_WIDTH-1:0]        wrPtr;
    logic [CW-1:0]                fillCount;
    logic                         lfoValid;
    logic signed [DATA_WIDTH-1:0] pktLatched;
    logic signed [EW-1:0]         extraLatched;
    logic signed [DATA_WIDTH-1:0] sampleA;

    logic signed [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic signed [DATA_WIDTH-1:0] ramQ;
    logic [IW-1:0]                ramAddr;
    logic                         ramWe;

    logic signed [DW-1:0]         dRaw;
    logic signed [DW-1:0]         dClamp;
    logic [ADDR_WIDTH-1:0]        delayInt;
    logic [FRAC_BITS-1:0]         delayFrac;
    logic [CW-1:0]                wrExt;
    logic [CW-1:0]                diExt;
    logic [CW-1:0]                addrA;
    logic [CW-1:0]                addrB;
    logic                         aValid;
    logic                         bValid;

    logic signed [DATA_WIDTH-1:0] sampleB;
    logic signed [DATA_WIDTH:0]   diff;
    logic signed [PW-1:0]         prod;
    logic signed [DATA_WIDTH-1:0] interpY;

    // Delay in fixed point, clamped so both interpolation taps stay inside the buffer.
    always_comb begin
        dRaw = D_AVG + $signed({{2{extraLatched[EW-1]}}, extraLatched});
        if (dRaw[DW-1]) begin
            dClamp = '0;
        end else if (dRaw > D_MAX) begin
            dClamp = D_MAX;
        end else begin
            dClamp = dRaw;
        end
        delayInt  = ADDR_WIDTH'(dClamp >>> FRAC_BITS);
        delayFrac = FRAC_BITS'(dClamp);
    end

    always_comb begin
        wrExt = {1'b0, wrPtr};
        diExt = {1'b0, delayInt};
        if (diExt > wrExt) begin
            addrA = wrExt + DEPTH_C - diExt;
        end else begin
            addrA = wrExt - diExt;
        end
        if (addrA == '0) begin
            addrB = DEPTH_C - CW'(1);
        end else begin
            addrB = addrA - CW'(1);
        end
        aValid = diExt < fillCount;
        bValid = (diExt + CW'(1)) < fillCount;
    end

    always_comb begin
        ramAddr = IW'(wrPtr);
        ramWe   = 1'b0;
        case (state)
            S_WRITE:  ramWe   = 1'b1;
            S_READ_A: ramAddr = IW'(addrA);
            S_READ_B: ramAddr = IW'(addrB);
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ramWe) begin
            mem[ramAddr] <= pktLatched;
        end
        ramQ <= mem[ramAddr];
    end

    // ramQ holds tap B during INTERP; tap A was parked in sampleA one cycle earlier.
    always_comb begin
        sampleB = bValid ? ramQ : '0;
        diff    = {sampleB[DATA_WIDTH-1], sampleB} - {sampleA[DATA_WIDTH-1], sampleA};
        prod    = PW'(diff) * PW'($signed({1'b0, delayFrac}));
        interpY = sampleA + DATA_WIDTH'(prod >>> FRAC_BITS);
    end

    assign pktDelayedChanged_c_o = (state == S_OUTPUT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_RESET;
            wrPtr          <= '0;
            fillCount      <= '0;
            lfoValid       <= 1'b0;
            pktLatched     <= '0;
            extraLatched   <= '0;
            sampleA        <= '0;
            pktDelayed_s_o <= '0;
            errorLED_s_o   <= 1'b0;
        end else begin
            if (LFOChanged_s_i) begin
                extraLatched <= extraDelay_s_i;
                lfoValid     <= 1'b1;
            end else if (pktChanged_s_i) begin
                lfoValid <= 1'b0;
            end

            case (state)
                S_RESET: begin
                    wrPtr     <= '0;
                    fillCount <= '0;
                    state     <= S_IDLE;
                end
                S_IDLE: begin
                    if (pktChanged_s_i) begin
                        pktLatched <= pkt_s_i;
                        state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (fillCount != DEPTH_C) begin
                        fillCount <= fillCount + CW'(1);
                    end
                    if (pktChanged_s_i) begin
                        errorLED_s_o <= 1'b1;
                    end
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (pktChanged_s_i) begin
                        errorLED_s_o <= 1'b1;
                    end
                    if (lfoValid) begin
                        state <= S_READ_A;
                    end
                end
                S_READ_A: begin
                    if (pktChanged_s_i) begin
                        errorLED_s_o <= 1'b1;
                    end
                    state <= S_READ_B;
                end
                S_READ_B: begin
                    if (pktChanged_s_i) begin
                        errorLED_s_o <= 1'b1;
                    end
                    sampleA <= aValid ? ramQ : '0;
                    state   <= S_INTERP;
                end
                S_INTERP: begin
                    if (pktChanged_s_i) begin
                        errorLED_s_o <= 1'b1;
                    end
                    pktDelayed_s_o <= interpY;
                    state          <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    wrPtr <= (wrPtr == LAST_ADDR) ? '0 : wrPtr + ADDR_WIDTH'(1);
                    if (pktChanged_s_i) begin
                        pktLatched <= pkt_s_i;
                        state      <= S_WRITE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ERROR: begin
                    errorLED_s_o <= 1'b1;
                    state        <= S_RESET;
                end
                default: state <= S_ERROR;
            endcase
        end
    end
endmodule

// File: tb/tb_delay_line_interp.sv
// Bench for delay_line_interp: fixed vector tables, LFO-wait/wrap, overrun, reset abort and a randomized run against a history-queue model.
module tb_delay_line_interp;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 16;
    localparam int AVG   = 4;
    localparam int FB    = 4;
    localparam int EW    = AW + FB;
    localparam int ONE   = 1 << FB;

    typedef struct {
        bit rst;
        int pkt;
        int ext;
        int want;
    } vec_t;

    logic                 clk    = 1'b0;
    logic                 rst_n  = 1'b0;
    logic signed [DW-1:0] pkt    = '0;
    logic                 pktChg = 1'b0;
    logic signed [EW-1:0] extra  = '0;
    logic                 lfoChg = 1'b0;
    logic signed [DW-1:0] outDat;
    logic                 outChg;
    logic                 errLed;

    int   total = 0;
    int   bad   = 0;
    int   hist[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    delay_line_interp #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BUF_DEPTH (DEPTH),
        .AVG_DELAY (AVG),
        .FRAC_BITS (FB)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .pkt_s_i              (pkt),
        .pktChanged_s_i       (pktChg),
        .extraDelay_s_i       (extra),
        .LFOChanged_s_i       (lfoChg),
        .pktDelayed_s_o       (outDat),
        .pktDelayedChanged_c_o(outChg),
        .errorLED_s_o         (errLed)
    );

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    function automatic int floorDiv(input int num, input int den);
        int q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q--;
        return q;
    endfunction

    // Expected output for the newest sample in hist, from the delay/priming/interpolation rules.
    function automatic int modelOut(input int e);
        int d, di, f, n, cnt, a, b;
        d = AVG * ONE + e;
        if (d < 0) d = 0;
        if (d > (DEPTH - 2) * ONE) d = (DEPTH - 2) * ONE;
        di  = d / ONE;
        f   = d % ONE;
        n   = hist.size();
        cnt = (n < DEPTH) ? n : DEPTH;
        a   = (di < cnt) ? hist[n - 1 - di] : 0;
        b   = (di + 1 < cnt) ? hist[n - 2 - di] : 0;
        return a + floorDiv((b - a) * f, ONE);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n  = 1'b0;
        pktChg = 1'b0;
        lfoChg = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        hist.delete();
    endtask

    task automatic strobeIn(input int v, input int e, input bit withLfo);
        pkt    = DW'(v);
        extra  = EW'(e);
        pktChg = 1'b1;
        lfoChg = withLfo;
        tick();
        pktChg = 1'b0;
        lfoChg = 1'b0;
        hist.push_back(v);
    endtask

    task automatic waitOut(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 64) begin
            tick();
            n++;
            seen = outChg;
        end
        if (!seen) n = -1;
    endtask

    initial begin
        int n, want, cnt, gap, e, v;

        for (int i = 1; i <= 12; i++)
            vecs.push_back(vec_t'{i == 1, 100 * i, 0, (i <= 4) ? 0 : 100 * (i - 4)});
        for (int i = 1; i <= 10; i++)
            vecs.push_back(vec_t'{i == 1, 100 * i, 8, (i <= 4) ? 0 : (i == 5) ? 50 : 100 * i - 450});
        for (int i = 1; i <= 6; i++)
            vecs.push_back(vec_t'{i == 1, 100 * i, -200, 100 * i});
        for (int i = 1; i <= 16; i++)
            vecs.push_back(vec_t'{i == 1, 100 * i, 1000, (i <= 14) ? 0 : 100 * (i - 14)});

        repeat (3) tick();
        check("rst_out", outDat, 0);
        check("rst_err", errLed, 0);
        check("rst_stb", outChg, 0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            tick();
            if (outChg) cnt++;
        end
        check("idle_no_stb", cnt, 0);
        check("idle_out", outDat, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) doReset();
            else if (i % 2 == 1) repeat (2) tick();
            strobeIn(vecs[i].pkt, vecs[i].ext, 1'b1);
            waitOut(n);
            check($sformatf("vec%0d_lat", i), n + 1, 6);
            check($sformatf("vec%0d_out", i), outDat, vecs[i].want);
        end
        check("err_clean", errLed, 0);

        doReset();
        for (int k = 1; k <= 40; k++) begin
            want = (k <= 4) ? 0 : 100 * (k - 4);
            if (k == 17) begin
                strobeIn(100 * k, 0, 1'b0);
                cnt = 0;
                repeat (20) begin
                    tick();
                    if (outChg) cnt++;
                end
                check("lfo_hold_no_stb", cnt, 0);
                extra  = '0;
                lfoChg = 1'b1;
                tick();
                lfoChg = 1'b0;
                waitOut(n);
                check("lfo_release_lat", n, 4);
            end else begin
                strobeIn(100 * k, 0, 1'b1);
                waitOut(n);
                check($sformatf("wrap%0d_lat", k), n + 1, 6);
            end
            check($sformatf("wrap%0d_out", k), outDat, want);
        end

        doReset();
        for (int k = 0; k < 80; k++) begin
            v   = int'($urandom_range(0, 65535)) - 32768;
            e   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3000)) - 1500
                                              : int'($urandom_range(0, 400)) - 200;
            gap = int'($urandom_range(0, 2));
            repeat (gap) tick();
            strobeIn(v, e, 1'b1);
            want = modelOut(e);
            waitOut(n);
            check($sformatf("rnd%0d_lat", k), n + 1, 6);
            check($sformatf("rnd%0d_out", k), outDat, want);
        end

        doReset();
        for (int k = 1; k <= 6; k++) begin
            strobeIn(100 * k, 0, 1'b1);
            waitOut(n);
        end
        check("pre_overrun_out", outDat, 200);
        strobeIn(700, 0, 1'b1);
        tick();
        tick();
        pkt    = 16'sd9999;
        pktChg = 1'b1;
        tick();
        pktChg = 1'b0;
        waitOut(n);
        check("overrun_lat", n, 2);
        check("overrun_out", outDat, 300);
        check("overrun_err", errLed, 1);
        for (int k = 8; k <= 12; k++) begin
            strobeIn(100 * k, 0, 1'b1);
            want = modelOut(0);
            waitOut(n);
            check($sformatf("post_overrun%0d", k), outDat, want);
        end
        check("err_sticky", errLed, 1);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("err_cleared", errLed, 0);
        check("out_cleared", outDat, 0);

        strobeIn(500, 0, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            tick();
            if (outChg) cnt++;
        end
        check("abort_no_stb", cnt, 0);
        check("abort_out", outDat, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
